// File: rtl/debounce_pkg.sv
// Shared helpers for the multi-channel debouncer: ms-to-cycle conversion,
// counter sizing and default timing constants.
package debounce_pkg;

    localparam int unsigned DEFAULT_STABLE_MS = 10;
    localparam int unsigned DEFAULT_LONG_MS   = 1000;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-FF synchroniser, stability counter, press/release
// pulses and, with DEBOUNCE_LONG_PRESS_EN defined, a long-press hold counter.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_MAX  = 1,
    parameter int unsigned LONG_MAX = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic btn_out,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    localparam int unsigned CNT_W = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    if (CNT_MAX < 1) begin : g_cnt_chk
        $fatal(1, "debounce_chan: CNT_MAX must be >= 1");
    end
    if (LONG_MAX < 2) begin : g_long_chk
        $fatal(1, "debounce_chan: LONG_MAX must be >= 2");
    end

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            cnt      <= '0;
            btn_out  <= 1'b0;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
        end else begin
            sync0    <= din;
            sync1    <= sync0;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            if (sync1 == btn_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_out  <= sync1;
                btn_rise <= sync1;
                btn_fall <= ~sync1;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = cnt_width(LONG_MAX);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_MAX);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_MAX - 2);

    logic [HOLD_W-1:0] hold_cnt;

    // Pulse is registered on the edge where hold_cnt steps to LONG_MAX-1;
    // the counter then parks at LONG_MAX so the pulse cannot repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= btn_out & ~btn_rise & (hold_cnt == HOLD_FIRE);
            if (!btn_out || btn_rise) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_SAT) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel button/switch conditioner: polarity mask plus one debounce_chan
// per input. Long-press detection is enabled by DEBOUNCE_LONG_PRESS_EN.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned    N_CH            = 4,
    parameter int unsigned    CLK_FREQ        = 125000000,
    parameter int unsigned    STABLE_MS       = DEFAULT_STABLE_MS,
    parameter int unsigned    LONG_MS         = DEFAULT_LONG_MS,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_out,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_long
);

    localparam int unsigned CNT_MAX  = ms_to_cycles(CLK_FREQ, STABLE_MS);
    localparam int unsigned LONG_MAX = ms_to_cycles(CLK_FREQ, LONG_MS);

    if (N_CH < 1 || N_CH > 32) begin : g_nch_chk
        $fatal(1, "debounce_multi: N_CH must be 1..32");
    end

    logic [N_CH-1:0] btn_pol;

    // Active-low inputs are flipped ahead of the synchroniser so every
    // channel works in "1 = pressed" terms from the first flop onward.
    assign btn_pol = btn_in ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_chan #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .din      (btn_pol[i]),
            .btn_out  (btn_out[i]),
            .btn_rise (btn_rise[i]),
            .btn_fall (btn_fall[i]),
            .btn_long (btn_long[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (CNT_MAX=4, LONG_MAX=10, ch2 active-low).
module tb_debounce_multi;

    localparam int unsigned N        = 4;
    localparam int unsigned CNT_MAX  = 4;
    localparam int unsigned LONG_CYC = 10;
    localparam logic [3:0]  MASK     = 4'b0100;
    localparam logic [3:0]  IDLE     = 4'b0100;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] btn_out, btn_rise, btn_fall, btn_long;

    debounce_multi #(
        .N_CH            (N),
        .CLK_FREQ        (1000),
        .STABLE_MS       (4),
        .LONG_MS         (10),
        .ACTIVE_LOW_MASK (MASK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_out  (btn_out),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_long (btn_long)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] lng;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (behaviour as seen from the pins)
    logic [3:0] m_s0 = '0, m_s1 = '0, m_out = '0;
    int         m_run[4];
    int         m_since[4];
    bit         m_valid[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [3:0] in, input logic r);
        exp_t e;
        exp_t g;
        e.rise = '0;
        e.fall = '0;
        e.lng  = '0;
        if (r) begin
            m_s0 = '0;
            m_s1 = '0;
            m_out = '0;
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0;
                m_valid[i] = 1'b0;
                m_since[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic old_out;
                old_out = m_out[i];
                if (m_s1[i] != m_out[i]) begin
                    m_run[i]++;
                    if (m_run[i] == CNT_MAX) begin
                        m_out[i]  = m_s1[i];
                        e.rise[i] = m_s1[i];
                        e.fall[i] = ~m_s1[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s1[i] = m_s0[i];
                m_s0[i] = in[i] ^ MASK[i];
                if (e.rise[i]) begin
                    m_since[i] = 0;
                    m_valid[i] = 1'b1;
                end else if (m_valid[i] && old_out) begin
                    m_since[i]++;
                end else begin
                    m_valid[i] = 1'b0;
                end
`ifdef DEBOUNCE_LONG_PRESS_EN
                e.lng[i] = m_valid[i] && (m_since[i] == LONG_CYC);
`endif
            end
        end
        e.out = m_out;
        sb.push_back(e);

        btn_in = in;
        rst    = r;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("btn_out",  {28'd0, btn_out},  {28'd0, g.out});
        check("btn_rise", {28'd0, btn_rise}, {28'd0, g.rise});
        check("btn_fall", {28'd0, btn_fall}, {28'd0, g.fall});
        check("btn_long", {28'd0, btn_long}, {28'd0, g.lng});
        check("rise_fall_excl", {28'd0, btn_rise & btn_fall}, 32'd0);
    endtask

    task automatic run(input logic [3:0] in, input int n);
        for (int k = 0; k < n; k++) tick(in, 1'b0);
    endtask

    initial begin
        int lat, cnt_a, cnt_b, rise_k, long_k;
        rst    = 1'b1;
        btn_in = IDLE;
        repeat (3) tick(IDLE, 1'b1);
        run(IDLE, 5);

        // Clean step on ch0
        lat = 0; cnt_a = 0; cnt_b = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(4'b0101, 1'b0);
            if (btn_out[0] && lat == 0) lat = k;
            if (btn_rise[0]) cnt_a++;
            if (btn_out[3:1] != 3'b000) cnt_b++;
        end
        check("ch0_latency", lat, 6);
        check("ch0_rise_count", cnt_a, 1);
        check("others_quiet", cnt_b, 0);
        run(IDLE, 12);

        // Bounce on ch1: 3 high, 1 low, 3 high, low
        cnt_a = 0;
        for (int k = 0; k < 17; k++) begin
            tick((k < 3 || (k >= 4 && k < 7)) ? 4'b0110 : IDLE, 1'b0);
            if (btn_out[1] || btn_rise[1] || btn_fall[1]) cnt_a++;
        end
        check("ch1_bounce_quiet", cnt_a, 0);

        // Short hold on ch0: release before long-press threshold
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            tick((k < 8) ? 4'b0101 : IDLE, 1'b0);
            if (btn_fall[0]) cnt_a++;
            if (btn_long[0]) cnt_b++;
        end
        check("ch0_short_fall", cnt_a, 1);
        check("ch0_short_nolong", cnt_b, 0);

        // Long hold on ch0
        cnt_a = 0; rise_k = -1; long_k = -1;
        for (int k = 0; k < 30; k++) begin
            tick(4'b0101, 1'b0);
            if (btn_rise[0]) rise_k = k;
            if (btn_long[0]) begin
                cnt_a++;
                long_k = k;
            end
        end
`ifdef DEBOUNCE_LONG_PRESS_EN
        check("ch0_long_count", cnt_a, 1);
        check("ch0_long_delay", long_k - rise_k, LONG_CYC);
`else
        check("ch0_long_count", cnt_a, 0);
        check("ch0_long_rise_seen", (rise_k >= 0) ? 32'd1 : 32'd0, 1);
`endif
        run(IDLE, 12);

        // Active-low ch2: raw 1 is released, raw 0 is pressed
        check("ch2_idle_low", {31'd0, btn_out[2]}, 0);
        cnt_a = 0;
        for (int k = 0; k < 10; k++) begin
            tick(4'b0000, 1'b0);
            if (btn_rise[2]) cnt_a++;
        end
        check("ch2_pressed", {31'd0, btn_out[2]}, 1);
        check("ch2_rise_count", cnt_a, 1);
        run(IDLE, 12);

        // Reset while ch3 cnt==2, then full requalification
        run(4'b1100, 4);
        tick(4'b1100, 1'b1);
        check("rst_outputs", {16'd0, btn_out, btn_rise, btn_fall, btn_long}, 0);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1100, 1'b0);
            if (btn_out[3] && lat == 0) lat = k;
        end
        check("ch3_post_rst_latency", lat, 6);
        run(IDLE, 12);

        // Simultaneous step on all channels
        lat = 0; cnt_a = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1011, 1'b0);
            if (btn_rise == 4'b1111 && lat == 0) lat = k;
            if (btn_rise != 4'b0000 && btn_rise != 4'b1111) cnt_a++;
        end
        check("all_rise_cycle", lat, 6);
        check("all_rise_partial", cnt_a, 0);
        run(IDLE, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
